// File: rtl/tick_gen_pkg.sv
// ---------------------------------------------------------------------------
// tick_gen_pkg
// Shared constants and helpers for the tick generator bank.
//   CNT_W_DEF   : default counter / divide-value width
//   MODE_TOGGLE : channel drives a square wave on divided_clk
//   MODE_PULSE  : channel only strobes tick, divided_clk held low
// ---------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int unsigned CNT_W_DEF   = 26;
    localparam logic        MODE_TOGGLE = 1'b0;
    localparam logic        MODE_PULSE  = 1'b1;

    // Square-wave output for the next cycle: follows the candidate phase in
    // toggle mode, forced low in pulse mode.
    function automatic logic wave_next(input logic mode, input logic phase);
        logic result;
        if (mode == MODE_TOGGLE) begin
            result = phase;
        end else begin
            result = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// ---------------------------------------------------------------------------
// tick_gen_channel
// One independent timebase: counts enabled cycles up to a programmable
// terminal value, strobing tick and optionally toggling a square wave.
// Divide values are staged in a shadow register and only take effect at a
// period boundary (terminal count, halted channel, or restart).
// Ports:
//   clk_in       : system clock, rising edge
//   rst          : synchronous active-low reset
//   en           : count enable
//   restart      : synchronous restart strobe (beats terminal count and en)
//   mode         : MODE_TOGGLE / MODE_PULSE
//   div_value    : divide value presented with load
//   load         : capture div_value into the shadow register
//   divided_clk  : registered square wave
//   tick         : registered one-cycle strobe at terminal count
//   load_pending : shadow value captured but not yet applied
// ---------------------------------------------------------------------------
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned      CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(49_999_999)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             mode,
    input  logic [CNT_W-1:0] div_value,
    input  logic             load,
    output logic             divided_clk,
    output logic             tick,
    output logic             load_pending
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             dclk_q, dclk_d;
    logic             tick_q, tick_d;

    logic terminal_s;
    logic boundary_s;
    logic apply_s;

    // Period-boundary detection: only here may a new period be adopted.
    always_comb begin
        terminal_s = en & (cnt_q == period_q);
        boundary_s = restart | terminal_s | ~en;
        apply_s    = boundary_s & (load | pend_q);
    end

    // Next-state logic for counter, outputs and the shadow/period pair.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        dclk_d   = dclk_q;
        tick_d   = 1'b0;

        if (restart) begin
            cnt_d  = '0;
            dclk_d = 1'b0;
            tick_d = 1'b0;
        end else if (terminal_s) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            dclk_d = wave_next(mode, ~dclk_q);
        end else if (en) begin
            cnt_d  = cnt_q + CNT_ONE;
            tick_d = 1'b0;
            dclk_d = wave_next(mode, dclk_q);
        end else begin
            // A halted channel adopting a new period restarts from zero so
            // the counter can never sit above a shrunken period.
            cnt_d  = apply_s ? '0 : cnt_q;
            tick_d = 1'b0;
            dclk_d = wave_next(mode, dclk_q);
        end

        // A load landing on a boundary bypasses the shadow entirely.
        if (boundary_s && load) begin
            period_d = div_value;
            pend_d   = 1'b0;
        end else if (boundary_s && pend_q) begin
            period_d = shadow_q;
            pend_d   = 1'b0;
        end else if (load) begin
            shadow_d = div_value;
            pend_d   = 1'b1;
        end else begin
            period_d = period_q;
            shadow_d = shadow_q;
            pend_d   = pend_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt_q    <= '0;
            period_q <= RESET_DIV;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            dclk_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            dclk_q   <= dclk_d;
            tick_q   <= tick_d;
        end
    end

    assign divided_clk  = dclk_q;
    assign tick         = tick_q;
    assign load_pending = pend_q;

endmodule

// File: rtl/tick_gen_bank.sv
// ---------------------------------------------------------------------------
// tick_gen_bank
// CHANNELS independent timebases from one clock. The top only slices the
// packed divide-value bus and gathers the per-channel registered outputs.
// Ports:
//   clk_in       : system clock, rising edge
//   rst          : synchronous active-low reset
//   en           : per-channel count enable
//   restart      : per-channel restart strobe
//   mode         : per-channel output mode (0 toggle, 1 pulse)
//   div_value    : packed divide values, channel i at [i*CNT_W +: CNT_W]
//   load         : per-channel shadow capture strobe
//   divided_clk  : per-channel square wave
//   tick         : per-channel terminal-count strobe
//   load_pending : per-channel staged-but-unapplied flag
// ---------------------------------------------------------------------------
module tick_gen_bank
    import tick_gen_pkg::*;
#(
    parameter int unsigned      CHANNELS  = 4,
    parameter int unsigned      CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RESET_DIV = 26'd49_999_999
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       restart,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*CNT_W-1:0] div_value,
    input  logic [CHANNELS-1:0]       load,
    output logic [CHANNELS-1:0]       divided_clk,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       load_pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tick_gen_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (RESET_DIV)
        ) u_channel (
            .clk_in       (clk_in),
            .rst          (rst),
            .en           (en[i]),
            .restart      (restart[i]),
            .mode         (mode[i]),
            .div_value    (div_value[i*CNT_W +: CNT_W]),
            .load         (load[i]),
            .divided_clk  (divided_clk[i]),
            .tick         (tick[i]),
            .load_pending (load_pending[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_bank.sv
// ---------------------------------------------------------------------------
// tb_tick_gen_bank
// Scenario tasks with directed expectations, backed by a per-channel
// behavioural model that tracks count, period, staged value and outputs.
// ---------------------------------------------------------------------------
module tb_tick_gen_bank;

    localparam int              CH   = 4;
    localparam int              CW   = 8;
    localparam logic [CW-1:0]   RDIV = 8'd6;

    logic             clk_in = 1'b0;
    logic             rst;
    logic [CH-1:0]    en, restart, mode, load;
    logic [CH*CW-1:0] div_value;
    logic [CH-1:0]    divided_clk, tick, load_pending;

    int checks   = 0;
    int failures = 0;

    // Model state, one entry per channel.
    int m_cnt[CH], m_period[CH], m_shadow[CH];
    bit m_pend[CH], m_dclk[CH], m_tick[CH];

    tick_gen_bank #(.CHANNELS(CH), .CNT_W(CW), .RESET_DIV(RDIV)) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .restart(restart), .mode(mode),
        .div_value(div_value), .load(load), .divided_clk(divided_clk),
        .tick(tick), .load_pending(load_pending)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Apply the channel rules for one rising edge using the current inputs.
    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            int dv;
            bit halted, terminal, boundary;
            dv = int'(div_value[c*CW +: CW]);
            if (!rst) begin
                m_cnt[c] = 0; m_period[c] = int'(RDIV); m_shadow[c] = 0;
                m_pend[c] = 0; m_dclk[c] = 0; m_tick[c] = 0;
            end else begin
                halted   = !en[c];
                terminal = en[c] && (m_cnt[c] == m_period[c]);
                boundary = restart[c] || terminal || halted;
                if (restart[c]) begin
                    m_cnt[c] = 0; m_dclk[c] = 0; m_tick[c] = 0;
                end else if (terminal) begin
                    m_cnt[c] = 0; m_tick[c] = 1;
                    m_dclk[c] = mode[c] ? 1'b0 : !m_dclk[c];
                end else begin
                    m_tick[c] = 0;
                    if (en[c]) m_cnt[c] = m_cnt[c] + 1;
                    if (mode[c]) m_dclk[c] = 0;
                end
                if (boundary && (load[c] || m_pend[c])) begin
                    m_period[c] = load[c] ? dv : m_shadow[c];
                    m_pend[c] = 0;
                    if (halted && !restart[c]) m_cnt[c] = 0;
                end else if (load[c]) begin
                    m_shadow[c] = dv;
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    function automatic logic [3*CH-1:0] model_outs();
        logic [CH-1:0] d, t, p;
        for (int c = 0; c < CH; c++) begin
            d[c] = m_dclk[c]; t[c] = m_tick[c]; p[c] = m_pend[c];
        end
        return {d, t, p};
    endfunction

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic set_div(input int c, input int v);
        div_value[c*CW +: CW] = CW'(v);
    endtask

    task automatic test_reset();
        int first;
        rst = 1'b0; en = '0; restart = '0; load = '0; mode = '0; div_value = '0;
        step(); step();
        checks++;
        if ({divided_clk, tick, load_pending} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 000", {divided_clk, tick, load_pending});
        end
        rst = 1'b1; en = '1;
        first = -1;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            step();
            checks++;
            if ({divided_clk, tick, load_pending} !== model_outs()) begin
                failures++;
                $display("FAIL reset_model k=%0d: got %h want %h", k, {divided_clk, tick, load_pending}, model_outs());
            end
            if (tick[0]) first = k;
        end
        checks++;
        if (first != int'(RDIV) + 1) begin
            failures++;
            $display("FAIL first_tick: got edge %0d want %0d", first, int'(RDIV) + 1);
        end
    endtask

    task automatic test_toggle_basic();
        int n_ticks, first, rises;
        logic prev;
        set_div(0, 3); load[0] = 1'b1; restart[0] = 1'b1;
        step();
        load = '0; restart = '0;
        checks++;
        if (load_pending[0] !== 1'b0 || divided_clk[0] !== 1'b0) begin
            failures++;
            $display("FAIL toggle_restart: pend=%b dclk=%b want 0 0", load_pending[0], divided_clk[0]);
        end
        n_ticks = 0; first = -1; rises = 0; prev = divided_clk[0];
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if ({divided_clk, tick, load_pending} !== model_outs()) begin
                failures++;
                $display("FAIL toggle_model k=%0d: got %h want %h", k, {divided_clk, tick, load_pending}, model_outs());
            end
            if (tick[0]) begin n_ticks++; if (first < 0) first = k; end
            if (divided_clk[0] && !prev) rises++;
            prev = divided_clk[0];
        end
        checks++;
        if (first != 4 || n_ticks != 4 || rises != 2) begin
            failures++;
            $display("FAIL toggle_period: first=%0d ticks=%0d rises=%0d want 4 4 2", first, n_ticks, rises);
        end
    endtask

    task automatic test_reload_mid_period();
        int tick_k;
        set_div(1, 9); load[1] = 1'b1; restart[1] = 1'b1;
        step();
        load = '0; restart = '0;
        for (int k = 0; k < 4; k++) step();
        set_div(1, 1); load[1] = 1'b1;
        step();
        load = '0;
        checks++;
        if (load_pending[1] !== 1'b1) begin
            failures++;
            $display("FAIL reload_pend_rise: got %b want 1", load_pending[1]);
        end
        tick_k = -1;
        for (int k = 1; k <= 20 && tick_k < 0; k++) begin
            step();
            checks++;
            if (load_pending[1] !== !tick[1]) begin
                failures++;
                $display("FAIL reload_pend k=%0d: pend=%b tick=%b", k, load_pending[1], tick[1]);
            end
            if (tick[1]) tick_k = k;
        end
        checks++;
        if (tick_k != 5) begin
            failures++;
            $display("FAIL reload_old_finish: got %0d want 5", tick_k);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (tick[1] !== ((k % 2) == 0) || {divided_clk, tick, load_pending} !== model_outs()) begin
                failures++;
                $display("FAIL reload_new_period k=%0d: got %h want %h", k, {divided_clk, tick, load_pending}, model_outs());
            end
        end
    endtask

    task automatic test_double_load();
        int guard;
        set_div(2, 7); load[2] = 1'b1; restart[2] = 1'b1;
        step();
        load = '0; restart = '0;
        step(); step();
        set_div(2, 5); load[2] = 1'b1; step();
        set_div(2, 2); load[2] = 1'b1; step();
        load = '0;
        checks++;
        if (load_pending[2] !== 1'b1) begin
            failures++;
            $display("FAIL dbl_pend: got %b want 1", load_pending[2]);
        end
        guard = 0;
        while (!tick[2] && guard < 20) begin step(); guard++; end
        checks++;
        if (!tick[2]) begin
            failures++;
            $display("FAIL dbl_boundary: no tick within 20 cycles");
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (tick[2] !== ((k % 3) == 0) || {divided_clk, tick, load_pending} !== model_outs()) begin
                failures++;
                $display("FAIL dbl_last_wins k=%0d: tick=%b want %b", k, tick[2], (k % 3) == 0);
            end
        end
        guard = 0;
        while (m_cnt[2] != m_period[2] && guard < 10) begin step(); guard++; end
        set_div(2, 4); load[2] = 1'b1;
        step();
        load = '0;
        checks++;
        if (tick[2] !== 1'b1 || load_pending[2] !== 1'b0) begin
            failures++;
            $display("FAIL coincident_load: tick=%b pend=%b want 1 0", tick[2], load_pending[2]);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (tick[2] !== (k == 5) || load_pending[2] !== 1'b0) begin
                failures++;
                $display("FAIL coincident_period k=%0d: tick=%b pend=%b", k, tick[2], load_pending[2]);
            end
        end
    endtask

    task automatic test_pause();
        logic hold_d;
        set_div(3, 6); load[3] = 1'b1; restart[3] = 1'b1;
        step();
        load = '0; restart = '0;
        step(); step(); step();
        hold_d = divided_clk[3];
        en[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (tick[3] !== 1'b0 || divided_clk[3] !== hold_d || {divided_clk, tick, load_pending} !== model_outs()) begin
                failures++;
                $display("FAIL pause_frozen k=%0d: tick=%b dclk=%b want 0 %b", k, tick[3], divided_clk[3], hold_d);
            end
        end
        en[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (tick[3] !== (k == 4)) begin
                failures++;
                $display("FAIL pause_resume k=%0d: tick=%b want %b", k, tick[3], k == 4);
            end
        end
        step(); step();
        set_div(3, 2); load[3] = 1'b1;
        step();
        load = '0; en[3] = 1'b0;
        step();
        checks++;
        if (load_pending[3] !== 1'b0) begin
            failures++;
            $display("FAIL pause_apply: pend=%b want 0", load_pending[3]);
        end
        step(); step(); step();
        en[3] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (tick[3] !== (k == 3)) begin
                failures++;
                $display("FAIL pause_cleared k=%0d: tick=%b want %b", k, tick[3], k == 3);
            end
        end
    endtask

    task automatic test_pulse_mode();
        logic prev;
        mode[0] = 1'b1; set_div(0, 0); load[0] = 1'b1; restart[0] = 1'b1;
        step();
        load = '0; restart = '0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (tick[0] !== 1'b1 || divided_clk[0] !== 1'b0) begin
                failures++;
                $display("FAIL pulse_div0 k=%0d: tick=%b dclk=%b want 1 0", k, tick[0], divided_clk[0]);
            end
        end
        mode[0] = 1'b0;
        step();
        prev = divided_clk[0];
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (divided_clk[0] !== !prev || tick[0] !== 1'b1) begin
                failures++;
                $display("FAIL toggle_div0 k=%0d: dclk=%b want %b", k, divided_clk[0], !prev);
            end
            prev = divided_clk[0];
        end
    endtask

    task automatic test_rst_mid_count();
        en = '1; restart = '0; load = '0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b0;
        step();
        checks++;
        if ({divided_clk, tick, load_pending} !== 12'h000) begin
            failures++;
            $display("FAIL rst_mid: got %h want 000", {divided_clk, tick, load_pending});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({divided_clk, tick, load_pending} !== 12'h000) begin
            failures++;
            $display("FAIL rst_between_edges: got %h want 000", {divided_clk, tick, load_pending});
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if ({divided_clk, tick, load_pending} !== model_outs() || tick !== ((k == int'(RDIV) + 1) ? 4'hF : 4'h0)) begin
                failures++;
                $display("FAIL rst_recover k=%0d: got %h want %h", k, {divided_clk, tick, load_pending}, model_outs());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CH; c++) begin
                en[c]      = ($urandom_range(0, 99) < 85);
                restart[c] = ($urandom_range(0, 99) < 3);
                load[c]    = ($urandom_range(0, 99) < 8);
                if ($urandom_range(0, 99) < 2) mode[c] = !mode[c];
                set_div(c, int'($urandom_range(0, 7)));
            end
            rst = ($urandom_range(0, 199) != 0);
            step();
            checks++;
            if ({divided_clk, tick, load_pending} !== model_outs()) begin
                failures++;
                $display("FAIL random k=%0d: got %h want %h", k, {divided_clk, tick, load_pending}, model_outs());
            end
        end
        rst = 1'b1; load = '0; restart = '0;
    endtask

    initial begin
        test_reset();
        test_toggle_basic();
        test_reload_mid_period();
        test_double_load();
        test_pause();
        test_pulse_mode();
        test_rst_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_gen_bank.md
# tick_gen_bank

Parametrised multi-channel successor to the single-channel toggle divider. Generates up to CHANNELS independent timebases from one system clock, each with its own divide value, enable, restart and output mode (square-wave toggle or one-cycle tick). Divide values can be reloaded at runtime and take effect glitch-free at the channel's next period boundary. Sits between the board clock and game logic: ball motion, paddle sampling, score blink and the audio beep rate.

## Interface
Parameters:
- CHANNELS, 4: number of independent channels (1..16)
- CNT_W, 26: counter / divide-value width per channel
- RESET_DIV, 26'd49_999_999: divide value loaded into every channel at reset

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low; sampled only on rising clk_in edge
- en  input  CHANNELS  per-channel count enable
- restart  input  CHANNELS  per-channel synchronous restart strobe
- mode  input  CHANNELS  0 = toggle (square wave on divided_clk), 1 = pulse (tick only, divided_clk held 0)
- div_value  input  CHANNELS*CNT_W  packed divide values; channel i = bits [i*CNT_W +: CNT_W]
- load  input  CHANNELS  per-channel strobe: capture div_value slice into shadow register
- divided_clk  output  CHANNELS  registered square-wave output per channel
- tick  output  CHANNELS  registered one-cycle strobe at each terminal count
- load_pending  output  CHANNELS  shadow value captured but not yet applied

## Operation
Per channel i, state: cnt[CNT_W], period[CNT_W], shadow[CNT_W], pend, divided_clk, tick.
- Reset (rst=0 at edge): cnt=0, period=RESET_DIV, shadow=0, pend=0, divided_clk=0, tick=0, for all channels.
- Terminal count: en=1 and cnt==period. At that edge: cnt<=0, tick<=1, divided_clk<=~divided_clk if mode=0, else divided_clk<=0.
- Non-terminal, en=1: cnt<=cnt+1, tick<=0; divided_clk holds (mode=0) or <=0 (mode=1).
- en=0: cnt holds, tick<=0, divided_clk holds (mode=0) or <=0 (mode=1).
- Toggle period = 2*(period+1) cycles; tick period = period+1 cycles. period=0: tick constant high, divided_clk toggles every cycle.
- load=1: shadow<=div_value slice, pend<=1. A second load before application overwrites shadow (last wins).
- Shadow application (period<=shadow, pend<=0) occurs at: terminal count, any edge with en=0, or restart. If load coincides with an application edge, the incoming div_value is written directly to period and pend stays 0.
- restart=1: cnt<=0, divided_clk<=0, tick<=0, pending shadow applied; overrides en and terminal count.
- Priority per edge: rst > restart > terminal count > increment/hold.
- Channels fully independent; no cross-channel interaction.
- Counter never exceeds period: if period is reduced below cnt, that cannot happen since application occurs only at cnt=0 boundaries or while halted (then cnt is compared with ==; halted channel with cnt>new period must wrap: rule: on application while en=0, cnt<=0).

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- First tick after reset with en held 1: edge number RESET_DIV+1 (tick high during cycle following that edge).
- load to effect: new period governs the count beginning after the next terminal edge; worst case latency = old period+1 cycles.
- load_pending rises the cycle after load, falls the cycle after application.
- restart: channel counts from 0 on the following cycle; next tick period+1 enabled cycles later.
- mode change takes effect at the next edge; no partial-phase correction.

## Structure
- Shared package tick_gen_pkg: CNT_W default, MODE_TOGGLE=1'b0, MODE_PULSE=1'b1 constants.
- One sub-module tick_gen_channel (single channel, all state above), instantiated CHANNELS times via generate; top only slices div_value and concatenates outputs.

## Test plan
- Reset then en=1, div=3, mode=0 on ch0 (via load+restart): divided_clk period 8 cycles, tick every 4 cycles, first tick 4 cycles after restart.
- Ch1 div=9 running; load div=1 mid-period at cnt=4: old period finishes (tick at cnt=9), then ticks every 2 cycles; load_pending high exactly between load and that tick.
- Two loads (5 then 2) before boundary: only 2 applied; load coincident with terminal edge applies immediately, pend never rises.
- en=0 for 10 cycles at cnt=3: cnt, divided_clk frozen, tick=0; resume completes remaining count; pending shadow applied and cnt cleared during pause.
- mode=1, div=0: tick constant 1, divided_clk 0; switch to mode=0: divided_clk toggles every cycle.
- rst asserted mid-count with all 4 channels active: all outputs 0 at next edge, rst deasserting between edges has no effect until sampled.
